// File: rtl/cycle_event_sched.sv
// Cycle counter, runtime-ratio clock divider and programmable per-cycle event
// table whose hits are delivered one at a time over a valid/ready output stage.
module cycle_event_sched #(
    parameter int CNT_W      = 32,
    parameter int DIV_W      = 8,
    parameter int NUM_EVENTS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic [DIV_W-1:0]      i_div_ratio,
    input  logic                  i_cfg_we,
    input  logic [IDX_W-1:0]      i_cfg_idx,
    input  logic                  i_cfg_en,
    input  logic [CNT_W-1:0]      i_cfg_cycle,
    output logic [CNT_W-1:0]      o_cycle_count,
    output logic                  o_div_clk,
    output logic                  o_evt_valid,
    input  logic                  i_evt_ready,
    output logic [IDX_W-1:0]      o_evt_id,
    output logic [CNT_W-1:0]      o_evt_cycle,
    output logic [NUM_EVENTS-1:0] o_overrun,
    input  logic                  i_clr_overrun
);

    logic [CNT_W-1:0]      r_cycle_count;
    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_div_clk;

    logic [NUM_EVENTS-1:0] r_en;
    logic [CNT_W-1:0]      r_match [NUM_EVENTS];
    logic [CNT_W-1:0]      r_cap   [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] r_pending;
    logic [NUM_EVENTS-1:0] r_overrun;

    logic                  r_evt_valid;
    logic [IDX_W-1:0]      r_evt_id;
    logic [CNT_W-1:0]      r_evt_cycle;

    logic [DIV_W-1:0]      w_ratio_m1;
    logic [NUM_EVENTS-1:0] w_hit;
    logic                  w_load;
    logic                  w_sel_found;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [CNT_W-1:0]      w_sel_cap;
    logic [NUM_EVENTS-1:0] w_drain;
    logic [NUM_EVENTS-1:0] w_pending_nxt;
    logic [NUM_EVENTS-1:0] w_overrun_nxt;

    // A zero ratio behaves as ratio 1 (toggle every run cycle).
    assign w_ratio_m1 = (i_div_ratio == '0) ? '0 : i_div_ratio - DIV_W'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if (i_run) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_div_clk <= 1'b0;
        end else if (i_run) begin
            if (r_div_cnt == '0) begin
                r_div_clk <= ~r_div_clk;
            end
            r_div_cnt <= (r_div_cnt >= w_ratio_m1) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_en <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_match[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (i_cfg_we && (i_cfg_idx == IDX_W'(i))) begin
                    r_en[i]    <= i_cfg_en;
                    r_match[i] <= i_cfg_cycle;
                end
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            w_hit[i] = i_run && r_en[i] && (r_match[i] == r_cycle_count);
        end
    end

    // Lowest pending index wins; uses pending state from before this edge's hits.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_cap   = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_cap   = r_cap[i];
            end
        end
    end

    assign w_load = !r_evt_valid || i_evt_ready;

    always_comb begin
        w_drain       = '0;
        w_pending_nxt = '0;
        w_overrun_nxt = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            w_drain[i]       = w_load && w_sel_found && (w_sel_idx == IDX_W'(i));
            w_pending_nxt[i] = w_hit[i] || (r_pending[i] && !w_drain[i]);
            // A fresh overrun beats a simultaneous clear.
            w_overrun_nxt[i] = (w_hit[i] && r_pending[i] && !w_drain[i])
                             || (r_overrun[i] && !i_clr_overrun);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
            r_overrun <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_cap[i] <= '0;
            end
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (w_hit[i]) begin
                    r_cap[i] <= r_cycle_count;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_evt_cycle <= '0;
        end else if (w_load) begin
            r_evt_valid <= w_sel_found;
            if (w_sel_found) begin
                r_evt_id    <= w_sel_idx;
                r_evt_cycle <= w_sel_cap;
            end
        end
    end

    assign o_cycle_count = r_cycle_count;
    assign o_div_clk     = r_div_clk;
    assign o_evt_valid   = r_evt_valid;
    assign o_evt_id      = r_evt_id;
    assign o_evt_cycle   = r_evt_cycle;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_cycle_event_sched.sv
// Directed bench for cycle_event_sched: a 32-bit counter instance for most
// scenarios and a 4-bit counter instance to reach the wrap/overrun cases.
module tb_cycle_event_sched;

    int compared   = 0;
    int mismatched = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        run = 0, cfg_we = 0, cfg_en = 0, evt_ready = 0, clr_overrun = 0;
    logic [7:0]  div_ratio = 8'd1;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_cycle = '0;
    logic [31:0] cycle_count, evt_cycle;
    logic        div_clk, evt_valid;
    logic [1:0]  evt_id;
    logic [3:0]  overrun;

    logic        s_run = 0, s_cfg_we = 0, s_cfg_en = 0, s_evt_ready = 0, s_clr_overrun = 0;
    logic [7:0]  s_div_ratio = 8'd1;
    logic [1:0]  s_cfg_idx = '0;
    logic [3:0]  s_cfg_cycle = '0;
    logic [3:0]  s_cycle_count, s_evt_cycle;
    logic        s_div_clk, s_evt_valid;
    logic [1:0]  s_evt_id;
    logic [3:0]  s_overrun;

    always #5 clk = ~clk;

    cycle_event_sched #(.CNT_W(32), .DIV_W(8), .NUM_EVENTS(4), .IDX_W(2)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_run(run), .i_div_ratio(div_ratio),
        .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_en(cfg_en), .i_cfg_cycle(cfg_cycle),
        .o_cycle_count(cycle_count), .o_div_clk(div_clk), .o_evt_valid(evt_valid),
        .i_evt_ready(evt_ready), .o_evt_id(evt_id), .o_evt_cycle(evt_cycle),
        .o_overrun(overrun), .i_clr_overrun(clr_overrun)
    );

    cycle_event_sched #(.CNT_W(4), .DIV_W(8), .NUM_EVENTS(4), .IDX_W(2)) u_dut_small (
        .i_clk(clk), .i_reset(rst), .i_run(s_run), .i_div_ratio(s_div_ratio),
        .i_cfg_we(s_cfg_we), .i_cfg_idx(s_cfg_idx), .i_cfg_en(s_cfg_en), .i_cfg_cycle(s_cfg_cycle),
        .o_cycle_count(s_cycle_count), .o_div_clk(s_div_clk), .o_evt_valid(s_evt_valid),
        .i_evt_ready(s_evt_ready), .o_evt_id(s_evt_id), .o_evt_cycle(s_evt_cycle),
        .o_overrun(s_overrun), .i_clr_overrun(s_clr_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        run = 0; evt_ready = 0; clr_overrun = 0; cfg_we = 0;
        s_run = 0; s_evt_ready = 0; s_clr_overrun = 0; s_cfg_we = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [31:0] cyc);
        cfg_we = 1; cfg_idx = idx; cfg_en = en; cfg_cycle = cyc;
        tick();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        #3;
        compared++; if (cycle_count !== 32'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        compared++; if (div_clk !== 1'b0) begin mismatched++; $display("FAIL reset_divclk: got %0b want 0", div_clk); end
        compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
        compared++; if (evt_id !== 2'd0 || evt_cycle !== 32'd0) begin mismatched++; $display("FAIL reset_evt: got id %0d cyc %0d want 0 0", evt_id, evt_cycle); end
        compared++; if (overrun !== 4'd0 || s_overrun !== 4'd0) begin mismatched++; $display("FAIL reset_overrun: got %0h/%0h want 0/0", overrun, s_overrun); end
        compared++; if (s_cycle_count !== 4'd0 || s_evt_valid !== 1'b0) begin mismatched++; $display("FAIL reset_small: got cnt %0d valid %0b want 0 0", s_cycle_count, s_evt_valid); end
        tick();
        rst = 0;
    endtask

    task automatic test_counter_div();
        logic exp_dc;
        apply_reset();
        div_ratio = 8'd10;
        run = 1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            exp_dc = ((k / 10) % 2) == 0;
            compared++; if (cycle_count !== 32'(k + 1)) begin mismatched++; $display("FAIL count_edge%0d: got %0d want %0d", k, cycle_count, k + 1); end
            compared++; if (div_clk !== exp_dc) begin mismatched++; $display("FAIL divclk_edge%0d: got %0b want %0b", k, div_clk, exp_dc); end
        end
        // div_cnt is 1 now; ratio 0 acts as 1, so it wraps without toggling first.
        div_ratio = 8'd0;
        tick();
        compared++; if (div_clk !== 1'b1) begin mismatched++; $display("FAIL div0_wrap: got %0b want 1", div_clk); end
        tick();
        compared++; if (div_clk !== 1'b0) begin mismatched++; $display("FAIL div0_t1: got %0b want 0", div_clk); end
        tick();
        compared++; if (div_clk !== 1'b1) begin mismatched++; $display("FAIL div0_t2: got %0b want 1", div_clk); end
        run = 0;
    endtask

    task automatic test_events();
        int mt [4] = '{1, 5, 10, 20};
        logic exp_v;
        int exp_id;
        apply_reset();
        cfg_write(2'd0, 1'b1, 32'd1);
        cfg_write(2'd1, 1'b1, 32'd5);
        cfg_write(2'd2, 1'b1, 32'd10);
        cfg_write(2'd3, 1'b1, 32'd20);
        evt_ready = 1;
        run = 1;
        for (int k = 0; k < 25; k++) begin
            tick();
            exp_v = 0; exp_id = 0;
            for (int j = 0; j < 4; j++) begin
                if (mt[j] == k - 1) begin exp_v = 1; exp_id = j; end
            end
            compared++; if (evt_valid !== exp_v) begin mismatched++; $display("FAIL ev_valid_edge%0d: got %0b want %0b", k, evt_valid, exp_v); end
            if (exp_v) begin
                compared++; if (evt_id !== 2'(exp_id) || evt_cycle !== 32'(k - 1)) begin mismatched++; $display("FAIL ev_data_edge%0d: got id %0d cyc %0d want id %0d cyc %0d", k, evt_id, evt_cycle, exp_id, k - 1); end
            end
        end
        compared++; if (overrun !== 4'd0) begin mismatched++; $display("FAIL ev_overrun: got %0h want 0", overrun); end
        run = 0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        cfg_write(2'd1, 1'b1, 32'd7);
        cfg_write(2'd2, 1'b1, 32'd7);
        evt_ready = 0;
        run = 1;
        repeat (8) tick();
        compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("FAIL same_pre: got %0b want 0", evt_valid); end
        tick();
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_cycle !== 32'd7) begin mismatched++; $display("FAIL same_first: got v%0b id %0d cyc %0d want v1 id 1 cyc 7", evt_valid, evt_id, evt_cycle); end
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_cycle !== 32'd7) begin mismatched++; $display("FAIL same_hold1_%0d: got v%0b id %0d cyc %0d want v1 id 1 cyc 7", k, evt_valid, evt_id, evt_cycle); end
        end
        evt_ready = 1;
        tick();
        evt_ready = 0;
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_cycle !== 32'd7) begin mismatched++; $display("FAIL same_second: got v%0b id %0d cyc %0d want v1 id 2 cyc 7", evt_valid, evt_id, evt_cycle); end
        repeat (2) tick();
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin mismatched++; $display("FAIL same_hold2: got v%0b id %0d want v1 id 2", evt_valid, evt_id); end
        evt_ready = 1;
        tick();
        evt_ready = 0;
        compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("FAIL same_empty: got %0b want 0", evt_valid); end
        run = 0;
    endtask

    task automatic test_overrun();
        apply_reset();
        s_cfg_we = 1; s_cfg_idx = 2'd0; s_cfg_en = 1; s_cfg_cycle = 4'd3;
        tick();
        s_cfg_we = 0;
        s_evt_ready = 0;
        s_run = 1;
        repeat (5) tick();  // edges 0..4: hit at edge 3, presented after edge 4
        compared++; if (s_evt_valid !== 1'b1 || s_evt_cycle !== 4'd3) begin mismatched++; $display("FAIL ovr_first: got v%0b cyc %0d want v1 cyc 3", s_evt_valid, s_evt_cycle); end
        repeat (15) tick(); // edges 5..19: second hit only refills pending
        compared++; if (s_overrun !== 4'd0) begin mismatched++; $display("FAIL ovr_second: got %0h want 0", s_overrun); end
        repeat (16) tick(); // edges 20..35: third hit with pending set
        compared++; if (s_overrun !== 4'b0001) begin mismatched++; $display("FAIL ovr_third: got %0h want 1", s_overrun); end
        compared++; if (s_evt_valid !== 1'b1 || s_evt_cycle !== 4'd3 || s_evt_id !== 2'd0) begin mismatched++; $display("FAIL ovr_held: got v%0b id %0d cyc %0d want v1 id 0 cyc 3", s_evt_valid, s_evt_id, s_evt_cycle); end
        s_clr_overrun = 1;
        tick();             // edge 36
        s_clr_overrun = 0;
        compared++; if (s_overrun !== 4'd0) begin mismatched++; $display("FAIL ovr_clear: got %0h want 0", s_overrun); end
        repeat (14) tick(); // edges 37..50
        s_clr_overrun = 1;
        tick();             // edge 51: new overrun and clear together
        s_clr_overrun = 0;
        compared++; if (s_overrun !== 4'b0001) begin mismatched++; $display("FAIL ovr_clr_race: got %0h want 1", s_overrun); end
        compared++; if (s_cycle_count !== 4'd4) begin mismatched++; $display("FAIL ovr_wrapcount: got %0d want 4", s_cycle_count); end
        s_run = 0;
    endtask

    task automatic test_run_freeze();
        apply_reset();
        cfg_write(2'd0, 1'b1, 32'd2);
        cfg_write(2'd1, 1'b1, 32'd2);
        cfg_write(2'd2, 1'b1, 32'd2);
        cfg_write(2'd3, 1'b1, 32'd3);
        div_ratio = 8'd2;
        evt_ready = 0;
        run = 1;
        repeat (3) tick();
        compared++; if (cycle_count !== 32'd3 || div_clk !== 1'b0 || evt_valid !== 1'b0) begin mismatched++; $display("FAIL frz_pre: got cnt %0d dc %0b v%0b want 3 0 0", cycle_count, div_clk, evt_valid); end
        run = 0;
        tick();
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_cycle !== 32'd2) begin mismatched++; $display("FAIL frz_e0: got v%0b id %0d cyc %0d want v1 id 0 cyc 2", evt_valid, evt_id, evt_cycle); end
        evt_ready = 1;
        tick();
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_cycle !== 32'd2) begin mismatched++; $display("FAIL frz_e1: got v%0b id %0d cyc %0d want v1 id 1 cyc 2", evt_valid, evt_id, evt_cycle); end
        tick();
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_cycle !== 32'd2) begin mismatched++; $display("FAIL frz_e2: got v%0b id %0d cyc %0d want v1 id 2 cyc 2", evt_valid, evt_id, evt_cycle); end
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++; if (evt_valid !== 1'b0 || cycle_count !== 32'd3 || div_clk !== 1'b0) begin mismatched++; $display("FAIL frz_idle%0d: got v%0b cnt %0d dc %0b want 0 3 0", k, evt_valid, cycle_count, div_clk); end
        end
        run = 1;
        tick();
        run = 0;
        compared++; if (evt_valid !== 1'b0 || cycle_count !== 32'd4) begin mismatched++; $display("FAIL frz_resume: got v%0b cnt %0d want 0 4", evt_valid, cycle_count); end
        tick();
        compared++; if (evt_valid !== 1'b1 || evt_id !== 2'd3 || evt_cycle !== 32'd3) begin mismatched++; $display("FAIL frz_e3: got v%0b id %0d cyc %0d want v1 id 3 cyc 3", evt_valid, evt_id, evt_cycle); end
        evt_ready = 0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        cfg_write(2'd0, 1'b1, 32'd1);
        evt_ready = 0;
        run = 1;
        repeat (3) tick();
        compared++; if (evt_valid !== 1'b1) begin mismatched++; $display("FAIL mid_pre: got %0b want 1", evt_valid); end
        #1 rst = 1;
        #1;
        compared++; if (evt_valid !== 1'b0 || cycle_count !== 32'd0 || evt_cycle !== 32'd0) begin mismatched++; $display("FAIL mid_async: got v%0b cnt %0d cyc %0d want 0 0 0", evt_valid, cycle_count, evt_cycle); end
        #1 rst = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            compared++; if (evt_valid !== 1'b0 || cycle_count !== 32'(k + 1)) begin mismatched++; $display("FAIL mid_after%0d: got v%0b cnt %0d want 0 %0d", k, evt_valid, cycle_count, k + 1); end
        end
        run = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_counter_div();
        test_events();
        test_same_cycle();
        test_overrun();
        test_run_freeze();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
